// File: rtl/wb_enc_pkg.sv
// Shared register indices, bit positions and master-FSM state type for wb_encoder_sampler.
package wb_enc_pkg;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_PERIOD   = 1;
    localparam int unsigned REG_STATUS   = 2;
    localparam int unsigned REG_POS0     = 4;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_TRIG    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_OVR     = 1;
    localparam int unsigned STAT_PEND    = 2;
    localparam int unsigned STAT_TO_LSB  = 8;
    localparam int unsigned STAT_CNT_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STORE,
        NEXT
    } m_state_t;

endpackage

// File: rtl/wb_encoder_sampler_if.sv
// Pipelined Wishbone bundle; used for both the CPU-facing slave port and the encoder-facing master port.
interface wb_encoder_sampler_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;

    modport master (output cyc, stb, we, addr, wdata, sel, input ack, stall, rdata);
    modport slave  (input cyc, stb, we, addr, wdata, sel, output ack, stall, rdata);
endinterface

// File: rtl/enc_sample_timer.sv
// Sweep-interval down-counter: one-cycle tick every PERIOD clocks while enabled and PERIOD is non-zero.
module enc_sample_timer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        en,
    input  logic [31:0] period,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        tick
);

    logic [31:0] cnt;

    // Reloading with period-1 makes the tick spacing exactly PERIOD clocks.
    assign tick = en && (period != '0) && (cnt == '0) && !load;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - 32'd1;
        end else if (!en || cnt == '0) begin
            cnt <= period - 32'd1;
        end else begin
            cnt <= cnt - 32'd1;
        end
    end

endmodule

// File: rtl/wb_encoder_sampler.sv
// Periodic Wishbone sweeper of NUM_CH encoder counts with position/velocity register bank.
// Optional sweep-done interrupt (o_irq, CTRL bit2, STATUS bit2) is built when SAMPLER_IRQ_EN is defined.
module wb_encoder_sampler
    import wb_enc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [29:0] ENC_BASE   = 30'h0,
    parameter logic [29:0] ENC_STRIDE = 30'h1,
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [31:0] PERIOD_RST = 32'd100000
) (
    input logic                 i_clk,
    input logic                 i_reset,
    wb_encoder_sampler_if.slave  wb,
    wb_encoder_sampler_if.master m
`ifdef SAMPLER_IRQ_EN
    ,
    output logic                o_irq
`endif
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic        ack_r;
    logic [31:0] rdata_r;
    logic [31:0] rd_mux;
    logic [31:0] status_word;
    logic [31:0] clr;
    logic [4:0]  idx;
    logic        accept, wr, wr_ctrl, wr_period, wr_status;
    logic        unused_bits;

    logic              ctrl_en;
    logic [31:0]       period;
    logic              overrun;
    logic [NUM_CH-1:0] to_flags;
    logic [15:0]       sweep_cnt;
    logic [31:0]       pos [NUM_CH];
    logic [31:0]       vel [NUM_CH];
    logic [NUM_CH-1:0] prev_valid;

    m_state_t         state, state_n;
    logic [CH_W-1:0]  ch;
    logic [TO_W-1:0]  wcnt;
    logic [31:0]      new_pos;
    logic             tick, trig, start_req, en_rise;
    logic             to_hit, sweep_done, m_cyc, m_stb;

    assign unused_bits = ^{wb.sel, wb.addr[29:5]};

    // Slave side: single-cycle ack, stall only on the ack cycle.
    assign idx       = wb.addr[4:0];
    assign accept    = wb.cyc && wb.stb && !wb.stall;
    assign wr        = accept && wb.we;
    assign wr_ctrl   = wr && (idx == 5'(REG_CTRL));
    assign wr_period = wr && (idx == 5'(REG_PERIOD));
    assign wr_status = wr && (idx == 5'(REG_STATUS));
    assign clr       = wr_status ? wb.wdata : '0;

    assign wb.ack   = ack_r;
    assign wb.stall = ack_r;
    assign wb.rdata = rdata_r;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            ack_r   <= accept;
            rdata_r <= (accept && !wb.we) ? rd_mux : '0;
        end
    end

    assign trig      = wr_ctrl && wb.wdata[CTRL_TRIG];
    assign start_req = tick || trig;
    assign en_rise   = wr_ctrl && wb.wdata[CTRL_EN] && !ctrl_en;

    enc_sample_timer u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .en       (ctrl_en),
        .period   (period),
        .load     (wr_period),
        .load_val (wb.wdata),
        .tick     (tick)
    );

    // Sticky flags: a set in the same cycle as a write-1 clear wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_en   <= 1'b0;
            period    <= PERIOD_RST;
            overrun   <= 1'b0;
            to_flags  <= '0;
            sweep_cnt <= '0;
        end else begin
            if (wr_ctrl)   ctrl_en <= wb.wdata[CTRL_EN];
            if (wr_period) period  <= wb.wdata;
            overrun <= (overrun && !clr[STAT_OVR]) || (start_req && state != IDLE);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                to_flags[i] <= (to_flags[i] && !clr[STAT_TO_LSB + i]) ||
                               (to_hit && ch == CH_W'(i));
            end
            if (sweep_done) sweep_cnt <= sweep_cnt + 16'd1;
        end
    end

`ifdef SAMPLER_IRQ_EN
    logic ctrl_irq_en;
    logic pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_irq_en <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_irq_en <= wb.wdata[CTRL_IRQ_EN];
            pending <= sweep_done || (pending && !clr[STAT_PEND]);
        end
    end

    assign o_irq = pending && ctrl_irq_en;
`endif

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY] = (state != IDLE);
        status_word[STAT_OVR]  = overrun;
`ifdef SAMPLER_IRQ_EN
        status_word[STAT_PEND] = pending;
`endif
        status_word[STAT_TO_LSB +: NUM_CH] = to_flags;
        status_word[STAT_CNT_LSB +: 16]    = sweep_cnt;
    end

    always_comb begin
        rd_mux = '0;
        case (idx)
            5'(REG_CTRL): begin
                rd_mux[CTRL_EN] = ctrl_en;
`ifdef SAMPLER_IRQ_EN
                rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
`endif
            end
            5'(REG_PERIOD): rd_mux = period;
            5'(REG_STATUS): rd_mux = status_word;
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (idx == 5'(REG_POS0 + 2 * i))     rd_mux = pos[i];
                    if (idx == 5'(REG_POS0 + 2 * i + 1)) rd_mux = vel[i];
                end
            end
        endcase
    end

    // Master FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        m_cyc      = 1'b0;
        m_stb      = 1'b0;
        to_hit     = 1'b0;
        sweep_done = 1'b0;
        case (state)
            IDLE:  if (start_req) state_n = REQ;
            REQ: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                if (!m.stall) state_n = WAIT;
            end
            WAIT: begin
                m_cyc = 1'b1;
                if (m.ack) begin
                    state_n = STORE;
                end else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                    to_hit  = 1'b1;
                    state_n = NEXT;
                end
            end
            STORE: state_n = NEXT;
            NEXT: begin
                if (ch == CH_W'(NUM_CH - 1)) begin
                    sweep_done = 1'b1;
                    state_n    = IDLE;
                end else begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ch      <= '0;
            wcnt    <= '0;
            new_pos <= '0;
        end else begin
            case (state)
                IDLE: ch <= '0;
                REQ:  wcnt <= '0;
                WAIT: begin
                    wcnt <= wcnt + TO_W'(1);
                    if (m.ack) new_pos <= m.rdata;
                end
                NEXT: if (state_n == REQ) ch <= ch + CH_W'(1);
                default: ;
            endcase
        end
    end

    // POS/VEL pair changes together in STORE, so CPU reads never see a torn pair.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pos[i] <= '0;
                vel[i] <= '0;
            end
            prev_valid <= '0;
        end else begin
            if (en_rise) prev_valid <= '0;
            if (state == STORE) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (ch == CH_W'(i)) begin
                        vel[i]        <= prev_valid[i] ? new_pos - pos[i] : '0;
                        pos[i]        <= new_pos;
                        prev_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign m.cyc   = m_cyc;
    assign m.stb   = m_stb;
    assign m.we    = 1'b0;
    assign m.addr  = m_stb ? ENC_BASE + 30'(ch) * ENC_STRIDE : '0;
    assign m.wdata = '0;
    assign m.sel   = {4{m_stb}};

endmodule

// File: tb/tb_wb_encoder_sampler.sv
// Directed self-checking bench for wb_encoder_sampler with a behavioural 4-channel encoder responder.
module tb_wb_encoder_sampler;
    import wb_enc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_encoder_sampler_if wb ();
    wb_encoder_sampler_if m ();

`ifdef SAMPLER_IRQ_EN
    logic irq;
    localparam logic [31:0] PEND = 32'h4;
`else
    localparam logic [31:0] PEND = 32'h0;
`endif

    wb_encoder_sampler #(
        .NUM_CH     (4),
        .ENC_BASE   (30'h0),
        .ENC_STRIDE (30'h1),
        .TIMEOUT    (16),
        .PERIOD_RST (32'd100000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (wb),
        .m       (m)
`ifdef SAMPLER_IRQ_EN
        ,
        .o_irq   (irq)
`endif
    );

    // Encoder responder: optional stall cycles per channel, ack one cycle after acceptance.
    logic [31:0] enc_cnt [4];
    int          stall_cfg [4];
    bit          noack [4];
    int          stall_cnt = 0;
    logic [1:0]  sel_ch;

    assign sel_ch = m.addr[1:0];
    always_comb m.stall = m.stb && (stall_cnt < stall_cfg[sel_ch]);

    always @(posedge clk) begin
        m.ack   <= 1'b0;
        m.rdata <= '0;
        if (m.cyc && m.stb) begin
            if (m.stall) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
                if (!noack[sel_ch]) begin
                    m.ack   <= 1'b1;
                    m.rdata <= enc_cnt[sel_ch];
                end
            end
        end else begin
            stall_cnt <= 0;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input int unsigned idx, input logic [31:0] wd,
                        output logic [31:0] rd);
        int unsigned n;
        @(posedge clk); #1;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we;
        wb.addr  = 30'(idx);
        wb.wdata = wd;
        wb.sel   = 4'hF;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb.ack && n < 20);
        rd = wb.rdata;
        chk("wb_ack_latency", 32'(n), 32'd1);
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
    endtask

    task automatic wr(input int unsigned idx, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, idx, d, dummy);
    endtask

    task automatic rd(input int unsigned idx, output logic [31:0] d);
        xfer(1'b0, idx, '0, d);
    endtask

    task automatic rchk(input string tag, input int unsigned idx, input logic [31:0] exp);
        logic [31:0] d;
        rd(idx, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_sweep(input int unsigned cnt);
        logic [31:0] s;
        int unsigned k;
        k = 0;
        do begin
            rd(REG_STATUS, s);
            k++;
        end while ((s[31:16] != cnt[15:0] || s[0]) && k < 200);
        chk("sweep_count", {16'b0, s[31:16]}, {16'b0, cnt[15:0]});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int unsigned k;

        rst = 1'b1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.addr = '0; wb.wdata = '0; wb.sel = '0;
        for (int i = 0; i < 4; i++) begin
            enc_cnt[i]   = 32'(100 * (i + 1));
            stall_cfg[i] = 0;
            noack[i]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   {31'b0, wb.ack},   32'd0);
        chk("rst_stall", {31'b0, wb.stall}, 32'd0);
        chk("rst_rdata", wb.rdata,          32'd0);
        chk("rst_mcyc",  {31'b0, m.cyc},    32'd0);
        chk("rst_mstb",  {31'b0, m.stb},    32'd0);
        chk("rst_maddr", {2'b0, m.addr},    32'd0);
        rst = 1'b0;

        rchk("rst_ctrl",   REG_CTRL,   32'd0);
        rchk("rst_period", REG_PERIOD, 32'd100000);
        rchk("rst_status", REG_STATUS, 32'd0);
        rchk("rst_pos0",   4,          32'd0);
        rchk("rst_vel3",   11,         32'd0);

        // Periodic sweeps: PERIOD=50, enable
        wr(REG_PERIOD, 32'd50);
        wr(REG_CTRL, 32'd1);
        wait_sweep(1);
        rchk("s1_pos0", 4, 32'd100);
        rchk("s1_pos1", 6, 32'd200);
        rchk("s1_pos2", 8, 32'd300);
        rchk("s1_pos3", 10, 32'd400);
        rchk("s1_vel0", 5, 32'd0);
        rchk("s1_vel3", 11, 32'd0);
        for (int i = 0; i < 4; i++) enc_cnt[i] = enc_cnt[i] + 32'd5;
        wait_sweep(2);
        wr(REG_CTRL, 32'd0);
        rchk("s2_pos0", 4, 32'd105);
        rchk("s2_pos3", 10, 32'd405);
        rchk("s2_vel0", 5, 32'd5);
        rchk("s2_vel1", 7, 32'd5);
        rchk("s2_vel2", 9, 32'd5);
        rchk("s2_vel3", 11, 32'd5);
        rchk("s2_status", REG_STATUS, 32'h0002_0000 | PEND);

        // Velocity across 32-bit wrap, trigger-driven
        wr(REG_PERIOD, 32'd0);
        enc_cnt[0] = 32'hFFFF_FFFE;
        wr(REG_CTRL, 32'd2);
        wait_sweep(3);
        rchk("wrap_pos0a", 4, 32'hFFFF_FFFE);
        enc_cnt[0] = 32'h0000_0003;
        wr(REG_CTRL, 32'd2);
        wait_sweep(4);
        rchk("wrap_pos0b", 4, 32'h0000_0003);
        rchk("wrap_vel0b", 5, 32'd5);
        enc_cnt[0] = 32'hFFFF_FFFD;
        wr(REG_CTRL, 32'd2);
        wait_sweep(5);
        rchk("wrap_vel0c", 5, 32'hFFFF_FFFA);
        rchk("wrap_vel1c", 7, 32'd0);
        rchk("trig_reads0", REG_CTRL, 32'd0);

        // Stall on channel 1, no ack on channel 2
        stall_cfg[1] = 3;
        noack[2]     = 1'b1;
        enc_cnt[1]   = 32'd1000;
        enc_cnt[2]   = 32'd2000;
        enc_cnt[3]   = 32'd3000;
        wr(REG_CTRL, 32'd2);
        wait_sweep(6);
        rchk("to_pos1", 6, 32'd1000);
        rchk("to_vel1", 7, 32'd795);
        rchk("to_pos2", 8, 32'd305);
        rchk("to_vel2", 9, 32'd0);
        rchk("to_pos3", 10, 32'd3000);
        rchk("to_vel3", 11, 32'd2595);
        rchk("to_status", REG_STATUS, 32'h0006_0400 | PEND);
        wr(REG_STATUS, 32'h0000_0400);
        rchk("to_clear", REG_STATUS, 32'h0006_0000 | PEND);
        stall_cfg[1] = 0;
        noack[2]     = 1'b0;

        // Overrun: second trigger two cycles into the sweep is dropped
        wr(REG_CTRL, 32'd2);
        wr(REG_CTRL, 32'd2);
        wait_sweep(7);
        repeat (40) @(posedge clk);
        rchk("ovr_status", REG_STATUS, 32'h0007_0002 | PEND);
        wr(REG_STATUS, 32'd2);
        rchk("ovr_clear", REG_STATUS, 32'h0007_0000 | PEND);

        // Read-only and unmapped registers
        wr(4, 32'd123);
        rchk("pos_ro", 4, 32'hFFFF_FFFD);
        rchk("unmapped3", 3, 32'd0);
        rchk("unmapped20", 20, 32'd0);

        // Reset while the master port waits for an ack
        noack[0] = 1'b1;
        wr(REG_CTRL, 32'd2);
        k = 0;
        while (!(m.cyc && !m.stb) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("in_wait", {31'b0, m.cyc && !m.stb}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstw_mcyc", {31'b0, m.cyc}, 32'd0);
        chk("rstw_mstb", {31'b0, m.stb}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        noack[0] = 1'b0;
        rchk("rstw_ctrl",   REG_CTRL,   32'd0);
        rchk("rstw_period", REG_PERIOD, 32'd100000);
        rchk("rstw_status", REG_STATUS, 32'd0);
        rchk("rstw_pos0",   4,          32'd0);
        rchk("rstw_vel0",   5,          32'd0);

        // First sweep after reset reports zero velocity
        wr(REG_CTRL, 32'd2);
        wait_sweep(1);
        rchk("post_pos2", 8, 32'd2000);
        rchk("post_vel2", 9, 32'd0);

`ifdef SAMPLER_IRQ_EN
        wr(REG_STATUS, 32'd4);
        chk("irq_cleared0", {31'b0, irq}, 32'd0);
        wr(REG_CTRL, 32'd6);
        chk("irq_busy", {31'b0, irq}, 32'd0);
        wait_sweep(2);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        rchk("irq_status", REG_STATUS, 32'h0002_0004);
        rchk("irq_ctrl", REG_CTRL, 32'd4);
        wr(REG_STATUS, 32'd4);
        chk("irq_fall", {31'b0, irq}, 32'd0);
`else
        wr(REG_CTRL, 32'd5);
        rchk("noirq_ctrl", REG_CTRL, 32'd1);
        rchk("noirq_status", REG_STATUS, 32'h0001_0000);
`endif

        d = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
